// File: rtl/base_tag_alloc.sv
// rtl/base_tag_alloc.sv - free-list tag allocator feeding the valid-bit memory set/reset ports.
// Self-fills the free list after reset, then hands out and reclaims tags.
module base_tag_alloc #(
  parameter int tag_width = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 o_alloc_v,
  output logic [tag_width-1:0] o_alloc_tag,
  input  logic                 i_alloc_r,
  input  logic                 i_free_v,
  input  logic [tag_width-1:0] i_free_tag,
  output logic                 o_set_v,
  output logic [tag_width-1:0] o_set_a,
  output logic                 o_rst_v,
  output logic [tag_width-1:0] o_rst_a,
  output logic                 o_init_done,
  output logic [tag_width:0]   o_free_cnt,
  output logic                 o_err
);

  localparam int depth = 1 << tag_width;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [tag_width-1:0] fifo_q [depth];
  logic [tag_width:0]   wr_ptr_q, wr_ptr_d;
  logic [tag_width:0]   rd_ptr_q, rd_ptr_d;
  logic [tag_width:0]   free_cnt_q, free_cnt_d;
  logic [depth-1:0]     in_use_q, in_use_d;
  logic [tag_width-1:0] init_cnt_q, init_cnt_d;
  logic                 set_v_q, set_v_d;
  logic [tag_width-1:0] set_a_q, set_a_d;
  logic                 rst_v_q, rst_v_d;
  logic [tag_width-1:0] rst_a_q, rst_a_d;
  logic                 err_q, err_d;

  logic                 alloc_v;
  logic                 accept;
  logic                 free_legal;
  logic [tag_width-1:0] head;
  logic                 wr_en;
  logic [tag_width-1:0] wr_data;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    in_use_d   = in_use_q;
    init_cnt_d = init_cnt_q;
    set_a_d    = set_a_q;
    rst_a_d    = rst_a_q;
    wr_en      = 1'b0;
    wr_data    = init_cnt_q;

    head       = fifo_q[rd_ptr_q[tag_width-1:0]];
    alloc_v    = (state_q == ST_RUN) && (free_cnt_q != '0);
    accept     = alloc_v && i_alloc_r;
    // In-use is sampled before this cycle's accept, so freeing the tag being handed out is illegal.
    free_legal = (state_q == ST_RUN) && i_free_v && in_use_q[i_free_tag];

    case (state_q)
      ST_INIT: begin
        wr_en      = 1'b1;
        wr_data    = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == tag_width'(depth - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (free_legal) begin
          wr_en   = 1'b1;
          wr_data = i_free_tag;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (accept) begin
      rd_ptr_d       = rd_ptr_q + 1'b1;
      in_use_d[head] = 1'b1;
      set_a_d        = head;
    end
    if (free_legal) begin
      in_use_d[i_free_tag] = 1'b0;
      rst_a_d              = i_free_tag;
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    free_cnt_d = free_cnt_q + (tag_width+1)'(wr_en) - (tag_width+1)'(accept);
    set_v_d    = accept;
    rst_v_d    = free_legal;
    err_d      = err_q || (i_free_v && !free_legal);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      free_cnt_q <= '0;
      in_use_q   <= '0;
      init_cnt_q <= '0;
      set_v_q    <= 1'b0;
      set_a_q    <= '0;
      rst_v_q    <= 1'b0;
      rst_a_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      free_cnt_q <= free_cnt_d;
      in_use_q   <= in_use_d;
      init_cnt_q <= init_cnt_d;
      set_v_q    <= set_v_d;
      set_a_q    <= set_a_d;
      rst_v_q    <= rst_v_d;
      rst_a_q    <= rst_a_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (wr_en) begin
      fifo_q[wr_ptr_q[tag_width-1:0]] <= wr_data;
    end
  end

  assign o_alloc_v   = alloc_v;
  assign o_alloc_tag = head;
  assign o_set_v     = set_v_q;
  assign o_set_a     = set_a_q;
  assign o_rst_v     = rst_v_q;
  assign o_rst_a     = rst_a_q;
  assign o_init_done = (state_q == ST_RUN);
  assign o_free_cnt  = free_cnt_q;
  assign o_err       = err_q;

endmodule

// File: doc/base_tag_alloc.md
# base_tag_alloc

Free-list tag allocator that sits directly upstream of the valid-bit memory: hands out unused tags to a requester over a valid/ready handshake, takes retired tags back, and drives the memory's set and reset ports with registered strobes. After reset it self-initialises the free list with every tag, detects illegal (double or unallocated) frees, and reports occupancy.

## Interface
- tag_width, 2, tag index width; depth = 2**tag_width tags.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- o_alloc_v  out  1  a free tag is offered.
- o_alloc_tag  out  tag_width  offered tag; meaningful only when o_alloc_v=1.
- i_alloc_r  in  1  consumer takes the offered tag this cycle.
- i_free_v  in  1  return a tag.
- i_free_tag  in  tag_width  tag being returned.
- o_set_v  out  1  set strobe toward the valid-bit memory.
- o_set_a  out  tag_width  address for o_set_v.
- o_rst_v  out  1  reset strobe toward the valid-bit memory.
- o_rst_a  out  tag_width  address for o_rst_v.
- o_init_done  out  1  free list initialised; allocation enabled.
- o_free_cnt  out  tag_width+1  number of tags currently in the free list.
- o_err  out  1  sticky: illegal free seen.

## Operation
- Storage: depth-entry free-list FIFO (register array), read/write pointers tag_width+1 bits wide (extra MSB for wrap), in-use bit vector of depth bits, free counter.
- FSM states INIT, RUN. Reset enters INIT.
- INIT: init counter 0..depth-1; each cycle writes counter value to FIFO at wr_ptr, increments wr_ptr and o_free_cnt. After writing depth-1, next state RUN and o_init_done=1. o_alloc_v=0 throughout INIT.
- RUN: o_alloc_v = (o_free_cnt != 0); o_alloc_tag = FIFO[rd_ptr] (combinational read of registered array). Accept = o_alloc_v & i_alloc_r: rd_ptr+1, in-use[tag]=1, free count -1. i_alloc_r with o_alloc_v=0 is ignored.
- Free: legal iff i_free_v and in-use[i_free_tag]=1 (value at start of cycle). Legal: write tag at wr_ptr, wr_ptr+1, in-use[tag]=0, free count +1. Illegal (tag not in use, or any free during INIT): dropped, no FIFO/in-use/count change, no o_rst_v, o_err set and held until reset.
- Simultaneous accept and legal free: both performed; count unchanged. Free of the tag being accepted in the same cycle is illegal (in-use not yet set) and flagged.
- Freed tag never bypasses to o_alloc_tag in the same cycle; empty list becomes non-empty the cycle after the free.
- Overflow impossible: in-use check bounds count at depth. Pointers wrap naturally modulo 2*depth; count is authoritative for empty.
- o_set_v/o_set_a: register of accept/accepted tag. o_rst_v/o_rst_a: register of legal free/tag. Both may be high together with different addresses.
- Reset mid-operation: all state cleared immediately, FSM restarts INIT; outstanding tags are forgotten (in-use all 0).

## Timing
- Reset values: o_alloc_v=0, o_alloc_tag=0, o_set_v=0, o_set_a=0, o_rst_v=0, o_rst_a=0, o_init_done=0, o_free_cnt=0, o_err=0.
- INIT lasts depth cycles after reset deassertion; o_init_done and o_alloc_v (tag 0) rise on cycle depth, o_free_cnt=depth.
- Accept in cycle N -> o_set_v in N+1; valid-bit memory read reflects it in N+3.
- Free in cycle N -> tag visible for re-offer no earlier than N+1 (after all older free-list entries); o_rst_v in N+1.
- Back-to-back accepts every cycle sustained while count > 0.
- o_err rises the cycle after the illegal free.

## Test plan
- tag_width=2: release reset, hold i_alloc_r=0 -> o_init_done=0 for 4 cycles, then 1; o_free_cnt=4; o_alloc_tag=0, o_alloc_v=1.
- Hold i_alloc_r=1 for 5 cycles -> tags 0,1,2,3 accepted in order, o_set_v/o_set_a 1 cycle later with 0..3, fifth cycle o_alloc_v=0, o_free_cnt=0.
- With list empty, free tag 2 -> o_rst_v/o_rst_a=2 next cycle, o_alloc_v=1 with tag 2 next cycle, o_free_cnt=1.
- Count=2, simultaneous accept of head tag and free of tag 1 -> o_free_cnt stays 2, o_set_v and o_rst_v both high next cycle with their tags.
- Free tag 3 twice (second not in use), and free during INIT -> second/INIT free dropped, o_err=1 sticky, o_free_cnt unchanged, no o_rst_v.
- Assert reset after allocating 3 tags -> all outputs to reset values asynchronously; INIT re-runs; tag 0 offered again after 4 cycles.
